// File: rtl/tx_parse_if.sv
// Transmit-path bundle for the egress PTP parser: XGMII in/out, TSU config and extracted header fields.
interface tx_parse_if;
    logic        tx_clk_en_i;
    logic [63:0] txd_i;
    logic [7:0]  txc_i;
    logic [63:0] txd_o;
    logic [7:0]  txc_o;
    logic [31:0] tsu_cfg_i;
    logic        txts_trig_o;
    logic        txts_valid_o;
    logic [3:0]  tx_messageType_o;
    logic [3:0]  tx_majorSdoId_o;
    logic [3:0]  tx_versionPTP_o;
    logic [15:0] tx_seqId_o;
    logic        int_tx_ptp_o;

    modport master (
        output tx_clk_en_i, txd_i, txc_i, tsu_cfg_i,
        input  txd_o, txc_o, txts_trig_o, txts_valid_o, tx_messageType_o,
               tx_majorSdoId_o, tx_versionPTP_o, tx_seqId_o, int_tx_ptp_o
    );

    modport slave (
        input  tx_clk_en_i, txd_i, txc_i, tsu_cfg_i,
        output txd_o, txc_o, txts_trig_o, txts_valid_o, tx_messageType_o,
               tx_majorSdoId_o, tx_versionPTP_o, tx_seqId_o, int_tx_ptp_o
    );
endinterface

// File: rtl/tx_parse.sv
// Egress XGMII parser: one-cycle pass-through, SOF trigger and PTPv2 event-message field extraction.
//   state | meaning
//   IDLE  | waiting for a start word in lane 0
//   HDR   | inside a frame, walking words to find ethertype and PTP header fields
//   DRAIN | frame classified (or not PTP); waiting for terminate
module tx_parse #(
    parameter logic [15:0] PTP_ETYPE  = 16'h88F7,
    parameter logic [15:0] VLAN_ETYPE = 16'h8100
) (
    input  logic      tx_clk,
    input  logic      tx_rst,
    tx_parse_if.slave bus
);
    localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;

    typedef enum logic [1:0] {IDLE, HDR, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic        vlan_q, vlan_d;
    logic [3:0]  sh_type_q, sh_type_d;
    logic [3:0]  sh_sdo_q, sh_sdo_d;
    logic [3:0]  sh_ver_q, sh_ver_d;
    logic [3:0]  type_q, type_d;
    logic [3:0]  sdo_q, sdo_d;
    logic [3:0]  ver_q, ver_d;
    logic [15:0] seq_q, seq_d;
    logic        trig_q, trig_d;
    logic        valid_q, valid_d;
    logic [63:0] txd_q;
    logic [7:0]  txc_q;

    logic [63:0] d;
    logic [7:0]  c;
    logic        en;
    logic        is_start, is_term, is_err;
    logic        cfg_unused;

    assign d          = bus.txd_i;
    assign c          = bus.txc_i;
    assign en         = bus.tx_clk_en_i;
    assign cfg_unused = ^{bus.tsu_cfg_i[31:3], bus.tsu_cfg_i[1]};
    assign is_start   = c[0] && (d[7:0] == 8'hFB);

    always_comb begin
        is_term = 1'b0;
        is_err  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (c[k] && (d[8*k +: 8] == 8'hFD)) is_term = 1'b1;
            if (c[k] && (d[8*k +: 8] == 8'hFE)) is_err  = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        vlan_d    = vlan_q;
        sh_type_d = sh_type_q;
        sh_sdo_d  = sh_sdo_q;
        sh_ver_d  = sh_ver_q;
        type_d    = type_q;
        sdo_d     = sdo_q;
        ver_d     = ver_q;
        seq_d     = seq_q;
        trig_d    = 1'b0;
        valid_d   = 1'b0;
        if (is_start) begin
            // A start always restarts parsing; the enable bit is sampled only here.
            wcnt_d = '0;
            vlan_d = 1'b0;
            if (bus.tsu_cfg_i[0]) begin
                state_d = HDR;
                trig_d  = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: ;
                HDR: begin
                    if (wcnt_q != 4'hF) wcnt_d = wcnt_q + 4'd1;
                    if (is_term || is_err) begin
                        state_d = IDLE;
                    end else begin
                        // wcnt_q is the index of the previous word, so the current word is wcnt_q+1
                        unique case (wcnt_q)
                            4'd1: begin
                                if ({d[39:32], d[47:40]} == PTP_ETYPE) begin
                                    sh_type_d = d[51:48];
                                    sh_sdo_d  = d[55:52];
                                    sh_ver_d  = d[59:56];
                                end else if ({d[39:32], d[47:40]} == VLAN_ETYPE) begin
                                    vlan_d = 1'b1;
                                end else begin
                                    state_d = DRAIN;
                                end
                            end
                            4'd2: begin
                                if (vlan_q) begin
                                    if ({d[7:0], d[15:8]} == PTP_ETYPE) begin
                                        sh_type_d = d[19:16];
                                        sh_sdo_d  = d[23:20];
                                        sh_ver_d  = d[27:24];
                                    end else begin
                                        state_d = DRAIN;
                                    end
                                end
                            end
                            4'd5, 4'd6: begin
                                if (vlan_q == (wcnt_q == 4'd6)) begin
                                    state_d = DRAIN;
                                    if (sh_type_q[3:2] == 2'b00) begin
                                        valid_d = 1'b1;
                                        type_d  = sh_type_q;
                                        sdo_d   = sh_sdo_q;
                                        ver_d   = sh_ver_q;
                                        seq_d   = vlan_q ? {d[7:0], d[15:8]} : {d[39:32], d[47:40]};
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                DRAIN: begin
                    if (is_term) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            vlan_q    <= 1'b0;
            sh_type_q <= '0;
            sh_sdo_q  <= '0;
            sh_ver_q  <= '0;
            type_q    <= '0;
            sdo_q     <= '0;
            ver_q     <= '0;
            seq_q     <= '0;
            trig_q    <= 1'b0;
            valid_q   <= 1'b0;
            txd_q     <= IDLE_WORD;
            txc_q     <= 8'hFF;
        end else if (en) begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            vlan_q    <= vlan_d;
            sh_type_q <= sh_type_d;
            sh_sdo_q  <= sh_sdo_d;
            sh_ver_q  <= sh_ver_d;
            type_q    <= type_d;
            sdo_q     <= sdo_d;
            ver_q     <= ver_d;
            seq_q     <= seq_d;
            trig_q    <= trig_d;
            valid_q   <= valid_d;
            txd_q     <= d;
            txc_q     <= c;
        end
    end

    // Pulses are held across disabled cycles and shown only on the next enabled one.
    assign bus.txd_o            = txd_q;
    assign bus.txc_o            = txc_q;
    assign bus.txts_trig_o      = trig_q & en;
    assign bus.txts_valid_o     = valid_q & en;
    assign bus.int_tx_ptp_o     = valid_q & en & bus.tsu_cfg_i[2];
    assign bus.tx_messageType_o = type_q;
    assign bus.tx_majorSdoId_o  = sdo_q;
    assign bus.tx_versionPTP_o  = ver_q;
    assign bus.tx_seqId_o       = seq_q;
endmodule

// File: tb/tb_tx_parse.sv
// Scoreboard bench for tx_parse: directed XGMII frames, expected pulses queued by the driver, checked by a monitor.
module tb_tx_parse;
    logic tx_clk = 1'b0;
    logic tx_rst;

    tx_parse_if bus();
    tx_parse dut (.tx_clk(tx_clk), .tx_rst(tx_rst), .bus(bus));

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        bit          is_valid;
        int          cyc;
        logic [3:0]  mt;
        logic [3:0]  sdo;
        logic [3:0]  ver;
        logic [15:0] seq;
        logic        intr;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          tgl = 1'b0;
    logic [63:0] m_d;
    logic [7:0]  m_c;
    logic [3:0]  ef_mt, ef_sdo, ef_ver;
    logic [15:0] ef_seq;

    always @(posedge tx_clk) cyc <= cyc + 1;

    // Reference one-stage pipeline for the pass-through path
    always @(posedge tx_clk or posedge tx_rst) begin
        if (tx_rst) begin
            m_d <= 64'h0707070707070707;
            m_c <= 8'hFF;
        end else if (bus.tx_clk_en_i) begin
            m_d <= bus.txd_i;
            m_c <= bus.txc_i;
        end
    end

    task automatic check_pulse(input bit is_v);
        exp_t e;
        checks++;
        if (bus.tx_clk_en_i !== 1'b1) begin
            failures++;
            $display("FAIL pulse_en cyc=%0d valid=%0b got_en=%b exp_en=1", cyc, is_v, bus.tx_clk_en_i);
        end
        checks++;
        if (q.size() == 0 || q[0].is_valid != is_v) begin
            failures++;
            $display("FAIL unexpected_%s cyc=%0d got=pulse exp=none", is_v ? "valid" : "trig", cyc);
        end else begin
            e = q[0];
            q.delete(0);
            checks++;
            if (e.cyc != cyc) begin
                failures++;
                $display("FAIL %s_timing got_cyc=%0d exp_cyc=%0d", is_v ? "valid" : "trig", cyc, e.cyc);
            end
            if (is_v) begin
                checks++;
                if ({bus.tx_messageType_o, bus.tx_majorSdoId_o, bus.tx_versionPTP_o, bus.tx_seqId_o, bus.int_tx_ptp_o}
                    !== {e.mt, e.sdo, e.ver, e.seq, e.intr}) begin
                    failures++;
                    $display("FAIL valid_fields got=%h/%h/%h/%h int=%b exp=%h/%h/%h/%h int=%b",
                             bus.tx_messageType_o, bus.tx_majorSdoId_o, bus.tx_versionPTP_o, bus.tx_seqId_o,
                             bus.int_tx_ptp_o, e.mt, e.sdo, e.ver, e.seq, e.intr);
                end
            end
        end
    endtask

    always @(negedge tx_clk) begin
        if (!tx_rst) begin
            checks++;
            if (bus.txd_o !== m_d || bus.txc_o !== m_c) begin
                failures++;
                $display("FAIL passthru cyc=%0d got=%h/%h exp=%h/%h", cyc, bus.txd_o, bus.txc_o, m_d, m_c);
            end
            while (q.size() > 0 && q[0].cyc < cyc) begin
                failures++;
                $display("FAIL missing_%s got=none exp_cyc=%0d", q[0].is_valid ? "valid" : "trig", q[0].cyc);
                q.delete(0);
            end
            if (bus.txts_trig_o !== 1'b0) check_pulse(1'b0);
            if (bus.txts_valid_o !== 1'b0) check_pulse(1'b1);
            checks++;
            if (bus.int_tx_ptp_o !== 1'b0 && bus.txts_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL int_no_valid cyc=%0d got=%b exp=0", cyc, bus.int_tx_ptp_o);
            end
        end
    end

    task automatic check_reset(input string name);
        checks++;
        if (bus.txd_o !== 64'h0707070707070707 || bus.txc_o !== 8'hFF) begin
            failures++;
            $display("FAIL %s_rst_data got=%h/%h exp=0707070707070707/ff", name, bus.txd_o, bus.txc_o);
        end
        checks++;
        if ({bus.txts_trig_o, bus.txts_valid_o, bus.int_tx_ptp_o} !== 3'b000) begin
            failures++;
            $display("FAIL %s_rst_pulses got=%b exp=000", name,
                     {bus.txts_trig_o, bus.txts_valid_o, bus.int_tx_ptp_o});
        end
        checks++;
        if ({bus.tx_messageType_o, bus.tx_majorSdoId_o, bus.tx_versionPTP_o, bus.tx_seqId_o} !== 28'h0) begin
            failures++;
            $display("FAIL %s_rst_fields got=%h/%h/%h/%h exp=0/0/0/0", name, bus.tx_messageType_o,
                     bus.tx_majorSdoId_o, bus.tx_versionPTP_o, bus.tx_seqId_o);
        end
    endtask

    task automatic check_fields(input string name);
        checks++;
        if ({bus.tx_messageType_o, bus.tx_majorSdoId_o, bus.tx_versionPTP_o, bus.tx_seqId_o}
            !== {ef_mt, ef_sdo, ef_ver, ef_seq}) begin
            failures++;
            $display("FAIL %s_held got=%h/%h/%h/%h exp=%h/%h/%h/%h", name, bus.tx_messageType_o,
                     bus.tx_majorSdoId_o, bus.tx_versionPTP_o, bus.tx_seqId_o, ef_mt, ef_sdo, ef_ver, ef_seq);
        end
    endtask

    task automatic put_word(input logic [63:0] dw, input logic [7:0] cw);
        bus.txd_i = dw;
        bus.txc_i = cw;
        bus.tx_clk_en_i = 1'b1;
        @(posedge tx_clk);
        #1;
        if (tgl) begin
            bus.tx_clk_en_i = 1'b0;
            bus.txd_i = 64'hDEADBEEF_CAFEF00D;
            bus.txc_i = 8'h00;
            @(posedge tx_clk);
            #1;
        end
    endtask

    task automatic push(input bit is_v, input logic [3:0] mt, input logic [3:0] sdo, input logic [3:0] ver,
                        input logic [15:0] seq, input logic intr);
        exp_t e;
        e.is_valid = is_v;
        e.cyc = cyc + (tgl ? 2 : 1);
        e.mt = mt; e.sdo = sdo; e.ver = ver; e.seq = seq; e.intr = intr;
        q.push_back(e);
    endtask

    // len = frame bytes before terminate; FD lands at word 1+len/8, lane len%8
    task automatic send_frame(input string name, input bit vlan, input logic [15:0] etype,
                              input logic [3:0] mt, input logic [3:0] sdo, input logic [3:0] ver,
                              input logic [15:0] seq, input int len, input bit exp_trig,
                              input bit exp_valid, input bit exp_int, input int rst_w);
        logic [7:0]  fb [0:127];
        logic [63:0] dw;
        logic [7:0]  cw;
        int          off, nw, cap_w;
        for (int i = 0; i < 128; i++) fb[i] = 8'(i * 7 + 3);
        fb[0] = 8'h01; fb[1] = 8'h1B; fb[2] = 8'h19; fb[3] = 8'h00; fb[4] = 8'h00; fb[5] = 8'h00;
        if (vlan) begin
            fb[12] = 8'h81; fb[13] = 8'h00; fb[14] = 8'h00; fb[15] = 8'h05;
            fb[16] = etype[15:8]; fb[17] = etype[7:0];
            off = 18;
            cap_w = 7;
        end else begin
            fb[12] = etype[15:8]; fb[13] = etype[7:0];
            off = 14;
            cap_w = 6;
        end
        fb[off]      = {sdo, mt};
        fb[off + 1]  = {4'h0, ver};
        fb[off + 30] = seq[15:8];
        fb[off + 31] = seq[7:0];
        nw = 1 + len / 8;
        if (exp_trig) push(1'b0, 4'h0, 4'h0, 4'h0, 16'h0, 1'b0);
        put_word(64'hD5555555555555FB, 8'h01);
        for (int w = 1; w <= nw; w++) begin
            for (int k = 0; k < 8; k++) begin
                int p;
                p = 8 * (w - 1) + k;
                if (p < len) begin
                    dw[8*k +: 8] = fb[p]; cw[k] = 1'b0;
                end else if (p == len) begin
                    dw[8*k +: 8] = 8'hFD; cw[k] = 1'b1;
                end else begin
                    dw[8*k +: 8] = 8'h07; cw[k] = 1'b1;
                end
            end
            if (w == cap_w && exp_valid) begin
                push(1'b1, mt, sdo, ver, seq, exp_int);
                ef_mt = mt; ef_sdo = sdo; ef_ver = ver; ef_seq = seq;
            end
            if (w == rst_w) begin
                bus.txd_i = dw;
                bus.txc_i = cw;
                bus.tx_clk_en_i = 1'b1;
                #2 tx_rst = 1'b1;
                #1 check_reset(name);
                ef_mt = 4'h0; ef_sdo = 4'h0; ef_ver = 4'h0; ef_seq = 16'h0;
                @(posedge tx_clk);
                #1 tx_rst = 1'b0;
            end else begin
                put_word(dw, cw);
            end
        end
        put_word(64'h0707070707070707, 8'hFF);
        put_word(64'h0707070707070707, 8'hFF);
        check_fields(name);
    endtask

    initial begin
        tx_rst = 1'b1;
        bus.tx_clk_en_i = 1'b1;
        bus.txd_i = 64'h0707070707070707;
        bus.txc_i = 8'hFF;
        bus.tsu_cfg_i = 32'd5;
        ef_mt = 4'h0; ef_sdo = 4'h0; ef_ver = 4'h0; ef_seq = 16'h0;
        #12 check_reset("por");
        @(posedge tx_clk);
        #1 tx_rst = 1'b0;
        put_word(64'h0707070707070707, 8'hFF);

        //          name        vlan  etype     mt    sdo   ver   seq       len trig valid int rst_w
        send_frame("sync",      1'b0, 16'h88F7, 4'h0, 4'h0, 4'h2, 16'h1234, 68, 1'b1, 1'b1, 1'b1, -1);
        send_frame("pdreq_vl",  1'b1, 16'h88F7, 4'h2, 4'h1, 4'h2, 16'hBEEF, 72, 1'b1, 1'b1, 1'b1, -1);
        send_frame("ipv4",      1'b0, 16'h0800, 4'h0, 4'h0, 4'h2, 16'h5555, 64, 1'b1, 1'b0, 1'b0, -1);
        send_frame("vl_ipv4",   1'b1, 16'h0800, 4'h1, 4'h0, 4'h2, 16'h6666, 72, 1'b1, 1'b0, 1'b0, -1);
        send_frame("sync2",     1'b0, 16'h88F7, 4'h0, 4'h0, 4'h2, 16'h1234, 68, 1'b1, 1'b1, 1'b1, -1);
        send_frame("followup",  1'b0, 16'h88F7, 4'h8, 4'h0, 4'h2, 16'h1235, 68, 1'b1, 1'b0, 1'b0, -1);
        send_frame("runt",      1'b0, 16'h88F7, 4'h1, 4'h0, 4'h2, 16'h0099, 27, 1'b1, 1'b0, 1'b0, -1);
        send_frame("dreq",      1'b0, 16'h88F7, 4'h1, 4'h0, 4'h2, 16'h0005, 64, 1'b1, 1'b1, 1'b1, -1);
        tgl = 1'b1;
        send_frame("sync_tgl",  1'b0, 16'h88F7, 4'h0, 4'h0, 4'h2, 16'h1234, 68, 1'b1, 1'b1, 1'b1, -1);
        tgl = 1'b0;
        bus.tsu_cfg_i = 32'd4;
        send_frame("cfg_off",   1'b0, 16'h88F7, 4'h0, 4'h0, 4'h2, 16'h7777, 68, 1'b0, 1'b0, 1'b0, -1);
        bus.tsu_cfg_i = 32'd1;
        send_frame("int_off",   1'b0, 16'h88F7, 4'h3, 4'h2, 4'h2, 16'h4242, 68, 1'b1, 1'b1, 1'b0, -1);
        bus.tsu_cfg_i = 32'd5;
        send_frame("rst_mid",   1'b1, 16'h88F7, 4'h0, 4'h0, 4'h2, 16'h9999, 72, 1'b1, 1'b0, 1'b0, 5);
        send_frame("after_rst", 1'b0, 16'h88F7, 4'h0, 4'h0, 4'h2, 16'h0ABC, 68, 1'b1, 1'b1, 1'b1, -1);

        repeat (4) put_word(64'h0707070707070707, 8'hFF);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover_expect got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tx_parse.md
Name: tx_parse

Overview:
- Egress-side parser for the PTPv2 timestamp unit. It sits on the 64-bit XGMII transmit path, between the MAC and the PCS.
- It passes transmit data through with fixed latency. It detects Layer-2 PTPv2 frames (ethertype 0x88F7, optionally behind one 802.1Q tag) and extracts the header fields the tx timestamp queue needs.
- It emits a trigger at start-of-frame so the SFD timestamp can be latched. It emits a valid strobe once an event message has been fully identified.

Parameters:
- PTP_ETYPE, 16'h88F7, ethertype that identifies a PTP frame.
- VLAN_ETYPE, 16'h8100, ethertype that identifies a single VLAN tag.

Ports:
- tx_clk  in  1  transmit clock.
- tx_rst  in  1  asynchronous, active-high reset.
- tx_clk_en_i  in  1  clock enable (gmii/mii adaptation); all state advances only when this is 1.
- txd_i  in  64  XGMII data; lane k = bits[8k+7:8k].
- txc_i  in  8  XGMII control, one bit per lane.
- txd_o  out  64  txd_i delayed by one enabled cycle.
- txc_o  out  8  txc_i delayed by one enabled cycle.
- tsu_cfg_i  in  32  bit0 = tx parse enable; bit2 = tx interrupt enable.
- txts_trig_o  out  1  one tx_clk pulse on the enabled cycle in which the start word appears on txd_o.
- txts_valid_o  out  1  one tx_clk pulse when an event PTP message's sequenceId has been captured.
- tx_messageType_o  out  4  held field.
- tx_majorSdoId_o  out  4  held field.
- tx_versionPTP_o  out  4  held field.
- tx_seqId_o  out  16  held field.
- int_tx_ptp_o  out  1  txts_valid_o & tsu_cfg_i[2].

Behaviour:
- Reset values:
  - txd_o = 64'h0707070707070707, txc_o = 8'hFF (idle).
  - All other outputs 0.
  - FSM = IDLE, word counter = 0.
- When tx_clk_en_i = 0: all registers hold, and pulse outputs are 0 in that cycle.
- Start detection: the start word is txc_i[0]=1 and txd_i[7:0]=8'hFB. Start is recognised in lane 0 only.
- Word counter:
  - The start word is word 0. Frame byte n (destination MAC byte 0 = n=0) is in word 1+n/8, lane n%8.
  - The counter is 4 bits and increments per enabled cycle while in HDR, saturating at 15.
- FSM states:
  - IDLE -> HDR on a start word when tsu_cfg_i[0]=1. txts_trig_o pulses on the following enabled cycle, aligned with the start word on txd_o. When tsu_cfg_i[0]=0, no trig is generated.
  - HDR, word 2: bytes 12-13 are in lanes 4-5, big-endian.
    - If they equal PTP_ETYPE: hdr offset = 14.
    - If they equal VLAN_ETYPE: check bytes 16-17 in word 3, lanes 0-1. If those equal PTP_ETYPE, hdr offset = 18; otherwise go to DRAIN.
    - Any other value: go to DRAIN.
  - HDR field capture:
    - Capture byte off+0: messageType = low nibble, majorSdoId = high nibble.
    - Capture byte off+1: versionPTP = low nibble.
    - Capture bytes off+30..31: sequenceId, big-endian. Without VLAN this is word 6, lanes 4-5; with VLAN, word 7, lanes 0-1.
    - Captured values go to shadow registers. The outputs update only at the valid point.
  - HDR -> DRAIN when sequenceId is captured:
    - If messageType is 0-3 (Sync, Delay_Req, Pdelay_Req, Pdelay_Resp): load the outputs and pulse txts_valid_o one cycle after the capturing word.
    - For general messages (type >= 8): no valid pulse, and the outputs are unchanged.
  - DRAIN -> IDLE on terminate: any lane with txc=1 and data 8'hFD.
- Abort conditions:
  - Terminate or error (txc=1, data 8'hFE) in any lane while in HDR -> IDLE, with no valid pulse.
  - A new start word while in HDR or DRAIN restarts parsing (word counter = 0), and a new trig is issued.
  - If tsu_cfg_i[0] is cleared mid-frame, the current frame completes normally; the change takes effect at the next start.
- Runt frames: a frame whose terminate arrives before the sequenceId bytes yields a trig without a valid. The downstream timestamp queue discards a trig not followed by a valid before the next trig.
- Pass-through: data/control are never modified. Latency is exactly one enabled cycle, independent of parse state.
- Async reset mid-frame: everything returns to reset values immediately. The remainder of the interrupted frame is ignored until the next start word.

Test Plan:
- Untagged Sync (messageType 0, seqId 16'h1234, versionPTP 2), tx_clk_en_i=1, cfg=5 -> trig 1 cycle after start; valid and int pulse at word 6 +1; seqId=1234, type=0, version=2; txd_o equals txd_i delayed 1 cycle.
- VLAN-tagged Pdelay_Req (type 2, seqId 16'hBEEF) -> valid at word 7 +1, seqId=BEEF; non-PTP ethertype 0x0800 -> trig only, no valid, outputs hold previous values.
- Follow_Up (type 8) -> trig, no valid; outputs retain the prior Sync values.
- Frame terminated at word 4 (FD in lane 3) -> trig, no valid, FSM back in IDLE; the next Delay_Req (seqId 5) parses correctly.
- tx_clk_en_i toggling 1/0 every other cycle with the same Sync frame -> identical fields; each pulse is 1 tx_clk wide, aligned to an enabled cycle.
- cfg bit0=0 -> no trig/valid; bit2=0 -> valid present, int_tx_ptp_o stays 0; tx_rst asserted mid-frame -> outputs return to reset values immediately, no valid.
